// File: rtl/seg_scan_ctr_if.sv
// seg_scan_ctr_if: display-side bundle between the time/alarm datapath and the scan controller.
// The brightness signal exists only when SEG_SCAN_DIM_EN is defined.
interface seg_scan_ctr_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] data;
  logic [DIGITS-1:0]   dp;
  logic [DIGITS-1:0]   blink_mask;
  logic                blink;
  logic                lzb_en;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]          brightness;
`endif
  logic [6:0]          seg_led;
  logic                seg_dp;
  logic [DIGITS-1:0]   An;
  logic                frame_start;

`ifdef SEG_SCAN_DIM_EN
  modport master (
    output data, dp, blink_mask, blink, lzb_en, brightness,
    input  seg_led, seg_dp, An, frame_start
  );
  modport slave (
    input  data, dp, blink_mask, blink, lzb_en, brightness,
    output seg_led, seg_dp, An, frame_start
  );
`else
  modport master (
    output data, dp, blink_mask, blink, lzb_en,
    input  seg_led, seg_dp, An, frame_start
  );
  modport slave (
    input  data, dp, blink_mask, blink, lzb_en,
    output seg_led, seg_dp, An, frame_start
  );
`endif
endinterface

// File: rtl/seg_scan_ctr.sv
// seg_scan_ctr: multiplexed seven-segment scanner with dead time, blink, decimal points,
// leading-zero blanking and per-frame input snapshot. Define SEG_SCAN_DIM_EN for PWM dimming.
module seg_scan_ctr #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2000
) (
  input  logic          clk,
  input  logic          rest_n,
  seg_scan_ctr_if.slave bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(DIGITS);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] dataSh_q, dataSh_d;
  logic [DIGITS-1:0]   dpSh_q, dpSh_d;
  logic [DIGITS-1:0]   maskSh_q, maskSh_d;
  logic [6:0]          segLed_q, segLed_d;
  logic                segDp_q, segDp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frameStart_q, frameStart_d;
`ifdef SEG_SCAN_DIM_EN
  logic [3:0]          brightSh_q, brightSh_d;
  logic [3:0]          pwm_q, pwm_d;
`endif

  logic       snap;
  logic       inDrive;
  logic       suppress;
  logic [3:0] curDigit;
  logic       curDp;
  logic       curMask;
  logic       upperZero;
  logic       lzbHit;
  logic [6:0] segDecoded;

  assign snap    = (cnt_q == '0) && (idx_q == '0);
  assign inDrive = (cnt_q >= CNT_W'(BLANK_CYC));

  // idx wraps at DIGITS-1, which need not be a power of two.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_comb begin
    dataSh_d = snap ? bus.data       : dataSh_q;
    dpSh_d   = snap ? bus.dp         : dpSh_q;
    maskSh_d = snap ? bus.blink_mask : maskSh_q;
`ifdef SEG_SCAN_DIM_EN
    brightSh_d = snap ? bus.brightness : brightSh_q;
    pwm_d      = pwm_q + 4'd1;
`endif
  end

  // Scan from the top digit down so lzbHit means "this digit and all above it are zero".
  always_comb begin
    curDigit  = 4'h0;
    curDp     = 1'b0;
    curMask   = 1'b0;
    upperZero = 1'b1;
    lzbHit    = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      upperZero = upperZero && (dataSh_q[4*k +: 4] == 4'h0);
      if (idx_q == IDX_W'(k)) begin
        curDigit = dataSh_q[4*k +: 4];
        curDp    = dpSh_q[k];
        curMask  = maskSh_q[k];
        lzbHit   = upperZero;
      end
    end
  end

  always_comb begin
    case (curDigit)
      4'h0: segDecoded = 7'b0000001;
      4'h1: segDecoded = 7'b1001111;
      4'h2: segDecoded = 7'b0010010;
      4'h3: segDecoded = 7'b0000110;
      4'h4: segDecoded = 7'b1001100;
      4'h5: segDecoded = 7'b0100100;
      4'h6: segDecoded = 7'b0100000;
      4'h7: segDecoded = 7'b0001111;
      4'h8: segDecoded = 7'b0000000;
      4'h9: segDecoded = 7'b0001100;
      4'hA: segDecoded = 7'b0001000;
      4'hB: segDecoded = 7'b1100000;
      4'hC: segDecoded = 7'b0110001;
      4'hD: segDecoded = 7'b1000010;
      4'hE: segDecoded = 7'b0110000;
      default: segDecoded = 7'b0111000;
    endcase
  end

  // Suppressed digits keep their segment pattern; only the anode is withheld.
  always_comb begin
    suppress = (curMask && bus.blink) || (bus.lzb_en && (idx_q != '0) && lzbHit);
`ifdef SEG_SCAN_DIM_EN
    suppress = suppress || (pwm_q > brightSh_q);
`endif
    an_d         = '1;
    segLed_d     = 7'b1111111;
    segDp_d      = 1'b1;
    frameStart_d = snap;
    if (inDrive) begin
      segLed_d = segDecoded;
      segDp_d  = ~curDp;
      if (!suppress) an_d = ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      dataSh_q     <= '0;
      dpSh_q       <= '0;
      maskSh_q     <= '0;
      segLed_q     <= 7'b1111111;
      segDp_q      <= 1'b1;
      an_q         <= '1;
      frameStart_q <= 1'b0;
`ifdef SEG_SCAN_DIM_EN
      brightSh_q   <= '0;
      pwm_q        <= '0;
`endif
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      dataSh_q     <= dataSh_d;
      dpSh_q       <= dpSh_d;
      maskSh_q     <= maskSh_d;
      segLed_q     <= segLed_d;
      segDp_q      <= segDp_d;
      an_q         <= an_d;
      frameStart_q <= frameStart_d;
`ifdef SEG_SCAN_DIM_EN
      brightSh_q   <= brightSh_d;
      pwm_q        <= pwm_d;
`endif
    end
  end

  assign bus.seg_led     = segLed_q;
  assign bus.seg_dp      = segDp_q;
  assign bus.An          = an_q;
  assign bus.frame_start = frameStart_q;
endmodule

// File: tb/tb_seg_scan_ctr.sv
// tb_seg_scan_ctr: scoreboard bench for seg_scan_ctr; a cycle-level reference model queues
// expected outputs and a negedge monitor compares them. Define SEG_SCAN_DIM_EN to cover dimming.
module tb_seg_scan_ctr;
  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 8;
  localparam int BLANK_CYC = 2;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
  } expT;

  logic clk = 1'b0;
  logic rest_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  expT  expQ[$];

  int   n = 0;
  int   shData[DIGITS];
  bit   shDp[DIGITS];
  bit   shMask[DIGITS];
  int   shBright = 0;
  logic [6:0] segTab [16];

  seg_scan_ctr_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_ctr #(
    .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk(clk),
    .rest_n(rest_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  initial segTab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                     7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                     7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                     7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dpv, input logic [3:0] mask,
                               input logic bl, input logic lzb, input logic [3:0] bright,
                               input int cycles);
    @(negedge clk);
    bus.data       = d;
    bus.dp         = dpv;
    bus.blink_mask = mask;
    bus.blink      = bl;
    bus.lzb_en     = lzb;
`ifdef SEG_SCAN_DIM_EN
    bus.brightness = bright;
`else
    if (bright == 4'hF) begin end
`endif
    repeat (cycles) @(negedge clk);
  endtask

  // Reference model: n counts edges since reset release; slot position and digit follow from it.
  always @(posedge clk) begin
    expT e;
    int  pos;
    int  dig;
    bit  off;
    bit  allZero;
    if (!rest_n) begin
      n = 0;
    end else begin
      pos = n % SCAN_DIV;
      dig = (n / SCAN_DIV) % DIGITS;
      if (pos == 0 && dig == 0) begin
        for (int k = 0; k < DIGITS; k++) begin
          shData[k] = int'(bus.data[4*k +: 4]);
          shDp[k]   = bus.dp[k];
          shMask[k] = bus.blink_mask[k];
        end
`ifdef SEG_SCAN_DIM_EN
        shBright = int'(bus.brightness);
`endif
      end
      off = shMask[dig] && bus.blink;
      if (bus.lzb_en && dig != 0) begin
        allZero = 1'b1;
        for (int k = dig; k < DIGITS; k++) if (shData[k] != 0) allZero = 1'b0;
        if (allZero) off = 1'b1;
      end
`ifdef SEG_SCAN_DIM_EN
      if ((n % 16) > shBright) off = 1'b1;
`endif
      e.an  = 4'hF;
      e.seg = 7'b1111111;
      e.dp  = 1'b1;
      e.fs  = (pos == 0 && dig == 0);
      if (pos >= BLANK_CYC) begin
        e.seg = segTab[shData[dig]];
        e.dp  = !shDp[dig];
        if (!off) e.an[dig] = 1'b0;
      end
      expQ.push_back(e);
      n++;
    end
  end

  always @(negedge clk) begin
    expT e;
    if (rest_n && expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput("An",          32'(bus.An),          32'(e.an));
      checkOutput("seg_led",     32'(bus.seg_led),     32'(e.seg));
      checkOutput("seg_dp",      32'(bus.seg_dp),      32'(e.dp));
      checkOutput("frame_start", 32'(bus.frame_start), 32'(e.fs));
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, " An"},          32'(bus.An),          32'hF);
    checkOutput({tag, " seg_led"},     32'(bus.seg_led),     32'h7F);
    checkOutput({tag, " seg_dp"},      32'(bus.seg_dp),      32'h1);
    checkOutput({tag, " frame_start"}, 32'(bus.frame_start), 32'h0);
  endtask

  initial begin
    bus.data       = 16'h1234;
    bus.dp         = 4'b0000;
    bus.blink_mask = 4'b0000;
    bus.blink      = 1'b0;
    bus.lzb_en     = 1'b0;
`ifdef SEG_SCAN_DIM_EN
    bus.brightness = 4'hF;
`endif
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rest_n = 1'b1;

    applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'hF, 70);
    applyStimulus(16'h5678, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'hF, 12);
    applyStimulus(16'h9ABC, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'hF, 70);
    applyStimulus(16'hDEF0, 4'b1010, 4'b0000, 1'b0, 1'b0, 4'hF, 40);
    applyStimulus(16'h0070, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'hF, 70);
    applyStimulus(16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'hF, 70);
    applyStimulus(16'h0305, 4'b0000, 4'b0000, 1'b0, 1'b1, 4'hF, 40);
    applyStimulus(16'h1234, 4'b0100, 4'b1100, 1'b1, 1'b0, 4'hF, 70);
    applyStimulus(16'h1234, 4'b0100, 4'b1100, 1'b0, 1'b0, 4'hF, 70);
    applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h0, 70);
    applyStimulus(16'h4321, 4'b0000, 4'b0000, 1'b0, 1'b0, 4'h7, 70);

    // Reset in the middle of a drive phase must blank without a clock edge.
    for (int i = 0; i < SCAN_DIV && (((n - 1) % SCAN_DIV) < BLANK_CYC + 1); i++) @(negedge clk);
    #2 rest_n = 1'b0;
    #1 checkResetState("mid reset");
    expQ.delete();
    repeat (2) @(negedge clk);
    checkResetState("held reset");
    rest_n = 1'b1;
    applyStimulus(16'h8421, 4'b0001, 4'b0000, 1'b0, 1'b0, 4'hF, 70);

    for (int i = 0; i < 60; i++) begin
      applyStimulus(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                    4'($urandom), int'($urandom_range(1, 20)));
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus(16'($urandom_range(0, 255)), 4'($urandom), 4'($urandom), 1'($urandom), 1'b1,
                    4'($urandom), int'($urandom_range(3, 30)));
    end
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
